// File: rtl/data_unstack_48bits_pkg.sv
// Shared types and constants for the 48-bit readback serializer.
package data_unstack_48bits_pkg;

    localparam int WORD_W    = 16;
    localparam int FRAME_W   = 48;
    localparam int NUM_WORDS = 3;

    // Index of the last word in send order.
    localparam logic [1:0] LAST_IDX = 2'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2,
        ST_W2   = 2'd3
    } state_t;

    // Send-order index of the word presented in a given state.
    function automatic logic [1:0] state_word_idx(input state_t st);
        logic [1:0] idx;
        case (st)
            ST_W0:   idx = 2'd0;
            ST_W1:   idx = 2'd1;
            ST_W2:   idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Map a send-order index onto the physical 16-bit slot of the frame.
    function automatic logic [1:0] send_slot(input logic [1:0] idx, input logic lsw_first);
        logic [1:0] slot;
        if (lsw_first) begin
            slot = idx;
        end else begin
            slot = LAST_IDX - idx;
        end
        return slot;
    endfunction

endpackage

// File: rtl/data_unstack_48bits_word_mux.sv
// Selects the 16-bit slice of the frame that goes out at a given send index.
// LSW_FIRST=1 sends [15:0] first, LSW_FIRST=0 sends [47:32] first.
module unstack_word_mux
    import data_unstack_48bits_pkg::*;
#(
    parameter bit LSW_FIRST = 1'b1
) (
    input  logic [FRAME_W-1:0] frame,
    input  logic [1:0]         word_idx,
    output logic [WORD_W-1:0]  word
);

    logic [1:0] slot_s;

    // Translate the send index into a slot and pick that slice.
    always_comb begin
        slot_s = send_slot(word_idx, LSW_FIRST);
        case (slot_s)
            2'd0:    word = frame[15:0];
            2'd1:    word = frame[31:16];
            2'd2:    word = frame[47:32];
            default: word = 16'h0000;
        endcase
    end

endmodule

// File: rtl/data_unstack_48bits.sv
// 48-bit to 3x16-bit readback serializer with valid/ready output handshake.
// Optional feature: define UNSTACK_PENDING_EN to add a one-entry pending
// frame buffer so frames can follow each other without an idle cycle.
module data_unstack_48bits
    import data_unstack_48bits_pkg::*;
#(
    parameter bit LSW_FIRST = 1'b1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [FRAME_W-1:0] Din_48B,
    input  logic               Load,
    output logic               Load_ready,
    output logic [WORD_W-1:0]  Dout_16B,
    output logic               Dout_valid,
    input  logic               Dout_ready,
    output logic [1:0]         Word_idx,
    output logic               Done,
    output logic               Overrun
);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [FRAME_W-1:0]   frame_r;
    logic [FRAME_W-1:0]   frame_nxt_s;
    logic [WORD_W-1:0]    dout_r;
    logic                 valid_r;
    logic [1:0]           idx_r;
    logic                 done_r;
    logic                 overrun_r;
    logic                 done_nxt_s;
    logic                 hs_s;
    logic                 load_ready_s;
    logic                 valid_nxt_s;
    logic [1:0]           idx_nxt_s;
    logic [WORD_W-1:0]    word_nxt_s;

`ifdef UNSTACK_PENDING_EN
    logic [FRAME_W-1:0]   pend_r;
    logic [FRAME_W-1:0]   pend_nxt_s;
    logic                 pend_valid_r;
    logic                 pend_valid_nxt_s;
`endif

    // Handshake uses the registered valid, so ready is ignored while idle.
    assign hs_s = valid_r & Dout_ready;

`ifdef UNSTACK_PENDING_EN
    assign load_ready_s = (state_r == ST_IDLE) || !pend_valid_r;
`else
    assign load_ready_s = (state_r == ST_IDLE);
`endif

    // Next state, next frame contents and pending-buffer bookkeeping.
    always_comb begin
        state_nxt_s = state_r;
        frame_nxt_s = frame_r;
        done_nxt_s  = 1'b0;
`ifdef UNSTACK_PENDING_EN
        pend_nxt_s       = pend_r;
        pend_valid_nxt_s = pend_valid_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (Load) begin
                    state_nxt_s = ST_W0;
                    frame_nxt_s = Din_48B;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_W0: begin
                if (hs_s) begin
                    state_nxt_s = ST_W1;
                end else begin
                    state_nxt_s = ST_W0;
                end
            end
            ST_W1: begin
                if (hs_s) begin
                    state_nxt_s = ST_W2;
                end else begin
                    state_nxt_s = ST_W1;
                end
            end
            ST_W2: begin
                if (hs_s) begin
                    done_nxt_s = 1'b1;
`ifdef UNSTACK_PENDING_EN
                    // Chain straight into the buffered frame, or into a
                    // load arriving on this very edge, to avoid a bubble.
                    if (pend_valid_r) begin
                        state_nxt_s      = ST_W0;
                        frame_nxt_s      = pend_r;
                        pend_valid_nxt_s = 1'b0;
                    end else if (Load) begin
                        state_nxt_s = ST_W0;
                        frame_nxt_s = Din_48B;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
`else
                    state_nxt_s = ST_IDLE;
`endif
                end else begin
                    state_nxt_s = ST_W2;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
`ifdef UNSTACK_PENDING_EN
        // A load during a frame parks in the buffer unless it was consumed
        // directly by the final handshake above.
        if ((state_r != ST_IDLE) && Load && !pend_valid_r &&
            !((state_r == ST_W2) && hs_s)) begin
            pend_nxt_s       = Din_48B;
            pend_valid_nxt_s = 1'b1;
        end else begin
        end
`endif
    end

    assign valid_nxt_s = (state_nxt_s != ST_IDLE);
    assign idx_nxt_s   = state_word_idx(state_nxt_s);

    // Word for the next cycle is selected ahead of time so Dout_16B is a flop.
    unstack_word_mux #(
        .LSW_FIRST (LSW_FIRST)
    ) u_word_mux (
        .frame    (frame_nxt_s),
        .word_idx (idx_nxt_s),
        .word     (word_nxt_s)
    );

    // FSM state, frame register and registered outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r   <= ST_IDLE;
            frame_r   <= 48'h0000_0000_0000;
            dout_r    <= 16'h0000;
            valid_r   <= 1'b0;
            idx_r     <= 2'd0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            frame_r   <= frame_nxt_s;
            dout_r    <= valid_nxt_s ? word_nxt_s : 16'h0000;
            valid_r   <= valid_nxt_s;
            idx_r     <= idx_nxt_s;
            done_r    <= done_nxt_s;
            overrun_r <= overrun_r | (Load & ~load_ready_s);
        end
    end

`ifdef UNSTACK_PENDING_EN
    // One-entry pending frame buffer.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pend_r       <= 48'h0000_0000_0000;
            pend_valid_r <= 1'b0;
        end else begin
            pend_r       <= pend_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
        end
    end
`endif

    assign Load_ready = load_ready_s;
    assign Dout_16B   = dout_r;
    assign Dout_valid = valid_r;
    assign Word_idx   = idx_r;
    assign Done       = done_r;
    assign Overrun    = overrun_r;

endmodule

// File: tb/tb_data_unstack_48bits.sv
// Bench for data_unstack_48bits: a word-queue reference model checked every
// cycle, directed literal scenarios, then randomized load/ready/reset traffic.
module tb_data_unstack_48bits;

`ifdef UNSTACK_PENDING_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [47:0] Din = 48'h0;
    logic        Load = 1'b0;
    logic        Dout_ready = 1'b0;

    logic        a_ready, a_valid, a_done, a_ovr;
    logic [15:0] a_dout;
    logic [1:0]  a_idx;
    logic        b_ready, b_valid, b_done, b_ovr;
    logic [15:0] b_dout;
    logic [1:0]  b_idx;

    always #5 Clock = ~Clock;

    data_unstack_48bits #(.LSW_FIRST(1'b1)) dut_a (
        .Clock(Clock), .Reset(Reset), .Din_48B(Din), .Load(Load),
        .Load_ready(a_ready), .Dout_16B(a_dout), .Dout_valid(a_valid),
        .Dout_ready(Dout_ready), .Word_idx(a_idx), .Done(a_done), .Overrun(a_ovr)
    );

    data_unstack_48bits #(.LSW_FIRST(1'b0)) dut_b (
        .Clock(Clock), .Reset(Reset), .Din_48B(Din), .Load(Load),
        .Load_ready(b_ready), .Dout_16B(b_dout), .Dout_valid(b_valid),
        .Dout_ready(Dout_ready), .Word_idx(b_idx), .Done(b_done), .Overrun(b_ovr)
    );

    typedef struct packed {
        logic [15:0] w_lsw;
        logic [15:0] w_msw;
        logic [1:0]  idx;
    } ent_t;

    ent_t q[$];
    logic exp_done = 1'b0;
    logic exp_ovr  = 1'b0;
    logic exp_ready;
    int   frames;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   d0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_frame(input logic [47:0] d);
        ent_t e;
        for (int k = 0; k < 3; k++) begin
            e.w_lsw = d[16*k +: 16];
            e.w_msw = d[16*(2-k) +: 16];
            e.idx   = 2'(k);
            q.push_back(e);
        end
    endfunction

    // Model: an accepted load queues three words; each handshake pops one.
    always @(negedge Clock) begin
        if (!Reset) begin
            q.delete();
            exp_done = 1'b0;
            exp_ovr  = 1'b0;
            chk("rst_valid", a_valid, 1'b0);
            chk("rst_dout", a_dout, 16'h0000);
            chk("rst_idx", a_idx, 2'd0);
            chk("rst_done", a_done, 1'b0);
            chk("rst_ovr", a_ovr, 1'b0);
            chk("rst_ready", a_ready, 1'b1);
            chk("rst_b_valid", b_valid, 1'b0);
        end else begin
            frames    = (q.size() + 2) / 3;
            exp_ready = PEND ? (frames < 2) : (q.size() == 0);
            chk("valid", a_valid, q.size() > 0);
            chk("b_valid", b_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("dout", a_dout, q[0].w_lsw);
                chk("idx", a_idx, q[0].idx);
                chk("b_dout", b_dout, q[0].w_msw);
                chk("b_idx", b_idx, q[0].idx);
            end
            chk("done", a_done, exp_done);
            chk("ovr", a_ovr, exp_ovr);
            chk("load_ready", a_ready, exp_ready);
            chk("b_done", b_done, exp_done);
            exp_done = 1'b0;
            if (q.size() > 0 && Dout_ready) begin
                if (q[0].idx == 2'd2) exp_done = 1'b1;
                void'(q.pop_front());
            end
            if (Load) begin
                if (exp_ready) push_frame(Din);
                else exp_ovr = 1'b1;
            end
        end
        if (a_done) done_cnt++;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #1 Reset = 1'b0;
        repeat (2) tick();
        Reset = 1'b1;
        tick();

        // Zero back-pressure frame.
        Din = 48'h3333_2222_1111; Load = 1'b1; Dout_ready = 1'b1;
        tick(); Load = 1'b0;
        chk("t1_w0", a_dout, 16'h1111); chk("t1_i0", a_idx, 2'd0);
        tick();
        chk("t1_w1", a_dout, 16'h2222); chk("t1_i1", a_idx, 2'd1);
        tick();
        chk("t1_w2", a_dout, 16'h3333); chk("t1_i2", a_idx, 2'd2);
        tick();
        chk("t1_done", a_done, 1'b1); chk("t1_ready", a_ready, 1'b1);
        chk("t1_valid", a_valid, 1'b0); chk("t1_ovr", a_ovr, 1'b0);
        tick();

        // Back-pressure held in W1 for five cycles.
        d0 = done_cnt;
        Load = 1'b1;
        tick(); Load = 1'b0;
        tick(); Dout_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_w", a_dout, 16'h2222); chk("t2_hold_i", a_idx, 2'd1);
            tick();
        end
        Dout_ready = 1'b1;
        chk("t2_w1", a_dout, 16'h2222);
        tick(); chk("t2_w2", a_dout, 16'h3333);
        tick(); chk("t2_done", a_done, 1'b1);
        tick(); chk("t2_done_cnt", done_cnt - d0, 1);

        // MSW-first order on the second instance.
        Din = 48'hAAAA_BBBB_CCCC; Load = 1'b1;
        tick(); Load = 1'b0;
        chk("t3_b0", b_dout, 16'hAAAA); chk("t3_a0", a_dout, 16'hCCCC);
        tick(); chk("t3_b1", b_dout, 16'hBBBB);
        tick(); chk("t3_b2", b_dout, 16'hCCCC);
        tick(); tick();

        // Load while busy.
        d0 = done_cnt;
        Din = 48'h3333_2222_1111; Load = 1'b1;
        tick(); Load = 1'b0;
        tick();
        Din = 48'h1; Load = 1'b1;
`ifdef UNSTACK_PENDING_EN
        tick();
        tick(); Load = 1'b0;
        chk("t4_ovr", a_ovr, 1'b1); chk("t4_pend_w0", a_dout, 16'h0001);
        chk("t4_done", a_done, 1'b1);
        repeat (4) tick();
        chk("t4_ovr_sticky", a_ovr, 1'b1); chk("t4_done_cnt", done_cnt - d0, 2);
`else
        tick(); Load = 1'b0;
        chk("t4_ovr", a_ovr, 1'b1); chk("t4_w2", a_dout, 16'h3333);
        tick(); chk("t4_done", a_done, 1'b1);
        tick(); tick();
        chk("t4_ovr_sticky", a_ovr, 1'b1); chk("t4_done_cnt", done_cnt - d0, 1);
`endif

        // Reset in the middle of a frame.
        d0 = done_cnt;
        Din = 48'h3333_2222_1111; Load = 1'b1;
        tick(); Load = 1'b0;
        tick();
        Reset = 1'b0;
        #1;
        chk("t5_valid", a_valid, 1'b0); chk("t5_dout", a_dout, 16'h0000);
        chk("t5_idx", a_idx, 2'd0); chk("t5_ovr", a_ovr, 1'b0);
        chk("t5_ready", a_ready, 1'b1); chk("t5_done", a_done, 1'b0);
        tick(); Reset = 1'b1;
        chk("t5_no_resend", a_valid, 1'b0);
        Din = 48'h0005_0004_0003; Load = 1'b1;
        tick(); Load = 1'b0;
        chk("t5_w0", a_dout, 16'h0003);
        tick(); chk("t5_w1", a_dout, 16'h0004);
        tick(); chk("t5_w2", a_dout, 16'h0005);
        tick(); chk("t5_done", a_done, 1'b1);
        tick(); chk("t5_done_cnt", done_cnt - d0, 1);

`ifdef UNSTACK_PENDING_EN
        // Two frames loaded in consecutive cycles stream without a gap.
        d0 = done_cnt;
        Din = 48'h0003_0002_0001; Load = 1'b1;
        tick();
        chk("t6_w1", a_dout, 16'h0001);
        Din = 48'h0006_0005_0004;
        tick(); Load = 1'b0;
        chk("t6_w2", a_dout, 16'h0002);
        for (int v = 3; v <= 6; v++) begin
            tick();
            chk("t6_wv", a_dout, 48'(v)); chk("t6_valid", a_valid, 1'b1);
        end
        tick(); tick();
        chk("t6_done_cnt", done_cnt - d0, 2); chk("t6_ovr", a_ovr, 1'b0);
`endif

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            Load       = ($urandom % 4) == 0;
            Din        = {16'($urandom()), $urandom()};
            Dout_ready = ($urandom % 4) != 0;
            Reset      = ($urandom % 600) != 0;
            tick();
        end
        Reset = 1'b1; Load = 1'b0; Dout_ready = 1'b1;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_unstack_48bits.md
# data_unstack_48bits

Readback serializer for the function-generator datapath, the transmit-side counterpart of the 48-bit data stacker. It captures a 48-bit word in one cycle and returns it as three 16-bit words over a valid/ready handshake, least-significant word first. This lets host-side logic read back stacked 48-bit settings (phase/frequency words) through the same 16-bit bus the stacker loads from.

## Interface
- LSW_FIRST, 1, word order: 1 sends [15:0], [31:16], [47:32]; 0 sends the reverse order
- Clock  input  1  sole clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- Din_48B  input  48  word to serialize, sampled on an accepted load
- Load  input  1  load request, single-cycle or held
- Load_ready  output  1  block can accept Load this cycle
- Dout_16B  output  16  current 16-bit word
- Dout_valid  output  1  Dout_16B holds a valid word
- Dout_ready  input  1  downstream accepts the word this cycle
- Word_idx  output  2  index of the word on Dout_16B (0, 1, 2) in send order
- Done  output  1  one-cycle pulse after the third word is accepted
- Overrun  output  1  sticky: Load was asserted while Load_ready was low

## Operation
- FSM states: IDLE, W0, W1, W2.
- IDLE: Load_ready=1, Dout_valid=0. When Load=1, the block captures Din_48B into the shift register and goes to W0.
- Wk (k=0..2): Dout_valid=1, Word_idx=k, Dout_16B=selected slice, Load_ready=0.
  - Handshake is valid&&ready at the rising edge.
  - On a handshake, W0 goes to W1 and W1 goes to W2.
  - On a handshake in W2, the FSM goes to IDLE and Done=1 in the following cycle.
- Without a handshake the state holds. Dout_16B and Word_idx stay stable while Dout_valid=1 and Dout_ready=0.
- A Load while Load_ready=0 is ignored. It sets Overrun, which only Reset clears.
- Dout_ready is ignored while Dout_valid=0.
- Reset values: state IDLE, shift register 0, Dout_16B=16'h0000, Dout_valid=0, Word_idx=0, Done=0, Overrun=0, Load_ready=1.
- Reset asserted mid-frame aborts the frame immediately. No Done is issued and no partial word is re-sent after reset.

## Timing
- Load accepted at edge n: Dout_valid=1 and word 0 present from cycle n+1.
- Zero back-pressure (Dout_ready held at 1): words in cycles n+1, n+2, n+3. Done=1 in cycle n+4, and Load_ready=1 in cycle n+4 also.
- Back-to-back frames: the next frame starts with a Load in cycle n+4 or later (the pending buffer below changes this). Throughput is 3 words per 4 cycles.
- All outputs are registered except Load_ready, which decodes directly from state (and from the pending flag when present).

## Configuration
- UNSTACK_PENDING_EN defined:
  - Adds a one-entry 48-bit pending register and a valid flag.
  - While the FSM is not IDLE, Load_ready = !pending_valid, and a Load stores Din_48B in the pending register.
  - On the W2 handshake, if pending_valid=1, the FSM goes directly to W0 with the pending data, and clears pending_valid the same edge. Done still pulses. Sustained throughput is 1 word/cycle.
  - Overrun is set only when both the frame and the pending entry are occupied.
- UNSTACK_PENDING_EN undefined:
  - No pending storage; behaviour is exactly as in Operation and Timing.
  - Load_ready = (state==IDLE).

## Structure
- Shared package: FSM state enum (IDLE/W0/W1/W2), WORD_W=16, FRAME_W=48, NUM_WORDS=3.
- One sub-module, unstack_word_mux: selects the 16-bit slice from the 48-bit register and Word_idx with LSW_FIRST applied.
- No sub-module for the pending register; it lives in the top level under the macro.

## Test plan
- Din_48B=48'h3333_2222_1111, Load 1 cycle, Dout_ready=1 -> Dout_16B 16'h1111, 16'h2222, 16'h3333 in cycles n+1..n+3 with Word_idx 0,1,2; Done in n+4; Overrun=0.
- Same word, Dout_ready low for 5 cycles during W1 -> Dout_16B holds 16'h2222 with Word_idx=1 for all 5 cycles, then progresses; exactly 3 handshakes and one Done.
- LSW_FIRST=0, Din_48B=48'hAAAA_BBBB_CCCC -> sequence 16'hAAAA, 16'hBBBB, 16'hCCCC.
- Load 48'h1 during W1 (macro undefined) -> frame output unchanged, Overrun=1 and stays 1; only one Done.
- Reset pulsed low in W1 -> all outputs at reset values asynchronously; next Load of 48'h0005_0004_0003 yields 3,4,5 correctly.
- Macro defined: Load 48'h0003_0002_0001 then 48'h0006_0005_0004 in consecutive cycles, Dout_ready=1 -> six consecutive valid words 1..6, two Done pulses, Overrun=0.
